// File: rtl/fmrv32im_div_ctrl.sv
// Issue/writeback controller for the M-extension divider: one outstanding request,
// a one-entry result cache, and flush/reset handling that never aborts the divider.
module fmrv32im_div_ctrl (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ISSUE_VALID,
    output logic        ISSUE_READY,
    input  logic [1:0]  ISSUE_OP,
    input  logic [31:0] ISSUE_RS1,
    input  logic [31:0] ISSUE_RS2,
    input  logic [4:0]  ISSUE_RD,
    input  logic        KILL,
    output logic        DIV_INST_DIV,
    output logic        DIV_INST_DIVU,
    output logic        DIV_INST_REM,
    output logic        DIV_INST_REMU,
    output logic [31:0] DIV_RS1,
    output logic [31:0] DIV_RS2,
    input  logic        DIV_WAIT,
    input  logic        DIV_READY,
    input  logic [31:0] DIV_RD,
    output logic        WB_VALID,
    output logic [4:0]  WB_ADDR,
    output logic [31:0] WB_DATA
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StBusy,
        StDrain,
        StWb
    } state_e;

    state_e      r_state;
    logic [1:0]  r_op;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [4:0]  r_rd;

    logic        r_c_valid;
    logic [1:0]  r_c_op;
    logic [31:0] r_c_rs1;
    logic [31:0] r_c_rs2;
    logic [31:0] r_c_data;

    logic [3:0]  r_strobe;
    logic        r_wb_valid;
    logic [4:0]  r_wb_addr;
    logic [31:0] r_wb_data;

    logic        w_accept;
    logic        w_hit;
    logic [3:0]  w_op_onehot;
    logic        w_unused_div_wait;

    // DIV_WAIT is informational only; the FSM keys purely off DIV_READY.
    assign w_unused_div_wait = DIV_WAIT;

    assign ISSUE_READY = (r_state == StIdle);
    assign w_accept    = ISSUE_READY & ISSUE_VALID & ~KILL;
    assign w_hit       = r_c_valid & (r_c_op == ISSUE_OP) & (r_c_rs1 == ISSUE_RS1)
                       & (r_c_rs2 == ISSUE_RS2);

    always_comb begin
        w_op_onehot = 4'b0000;
        unique case (ISSUE_OP)
            2'd0:    w_op_onehot = 4'b0001;
            2'd1:    w_op_onehot = 4'b0010;
            2'd2:    w_op_onehot = 4'b0100;
            2'd3:    w_op_onehot = 4'b1000;
            default: w_op_onehot = 4'b0000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= StIdle;
            r_op       <= 2'd0;
            r_rs1      <= 32'd0;
            r_rs2      <= 32'd0;
            r_rd       <= 5'd0;
            r_c_valid  <= 1'b0;
            r_c_op     <= 2'd0;
            r_c_rs1    <= 32'd0;
            r_c_rs2    <= 32'd0;
            r_c_data   <= 32'd0;
            r_strobe   <= 4'b0000;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= 5'd0;
            r_wb_data  <= 32'd0;
        end else begin
            r_strobe   <= 4'b0000;
            r_wb_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op  <= ISSUE_OP;
                        r_rs1 <= ISSUE_RS1;
                        r_rs2 <= ISSUE_RS2;
                        r_rd  <= ISSUE_RD;
                        if (w_hit) begin
                            r_state    <= StWb;
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= r_c_data;
                            r_wb_addr  <= ISSUE_RD;
                        end else begin
                            r_state  <= StStart;
                            r_strobe <= w_op_onehot;
                        end
                    end
                end
                StStart: begin
                    r_state <= KILL ? StDrain : StBusy;
                end
                StBusy: begin
                    if (DIV_READY) begin
                        r_c_valid <= 1'b1;
                        r_c_op    <= r_op;
                        r_c_rs1   <= r_rs1;
                        r_c_rs2   <= r_rs2;
                        r_c_data  <= DIV_RD;
                        // A flush landing on the result cycle still caches, but skips writeback.
                        if (KILL) begin
                            r_state <= StIdle;
                        end else begin
                            r_state    <= StWb;
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= DIV_RD;
                            r_wb_addr  <= r_rd;
                        end
                    end else if (KILL) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (DIV_READY) begin
                        r_c_valid <= 1'b1;
                        r_c_op    <= r_op;
                        r_c_rs1   <= r_rs1;
                        r_c_rs2   <= r_rs2;
                        r_c_data  <= DIV_RD;
                        r_state   <= StIdle;
                    end
                end
                StWb: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign DIV_INST_DIV  = r_strobe[0];
    assign DIV_INST_DIVU = r_strobe[1];
    assign DIV_INST_REM  = r_strobe[2];
    assign DIV_INST_REMU = r_strobe[3];
    assign DIV_RS1       = r_rs1;
    assign DIV_RS2       = r_rs2;

    // KILL during the writeback cycle must squash the already-registered valid.
    assign WB_VALID = r_wb_valid & ~KILL;
    assign WB_ADDR  = r_wb_addr;
    assign WB_DATA  = r_wb_data;

endmodule
